// File: rtl/mem_unit_pingpong_pkg.sv
// Shared types and sizing helpers for the ping-pong IFM store.
// Banks are addressed by a one-bit index.
package mem_unit_pingpong_pkg;

  localparam int NUM_BANKS = 2;

  typedef logic bank_t;

  function automatic int depth_of(input int ifm_size);
    return ifm_size * ifm_size;
  endfunction

endpackage

// File: rtl/mem_unit_pingpong_if.sv
// Producer and consumer bundle of the ping-pong IFM store.
// slave is the store side, master is the producer/consumer side.
interface mem_unit_pingpong_if #(
  parameter int DW  = 32,
  parameter int NCH = 3,
  parameter int AW  = 8
);
  import mem_unit_pingpong_pkg::*;

  logic               wr_valid;
  logic               wr_ready;
  logic [NCH*DW-1:0]  wr_data;
  logic               rd_en;
  logic [AW-1:0]      rd_addr_a;
  logic [AW-1:0]      rd_addr_b;
  logic [NCH*DW-1:0]  rd_data_a;
  logic [NCH*DW-1:0]  rd_data_b;
  logic               rd_data_valid;
  logic               rd_bank_valid;
  logic               rd_release;
  logic [1:0]         full_count;
  logic               err_release;

  modport slave (
    input  wr_valid, wr_data,
    input  rd_en, rd_addr_a, rd_addr_b,
    input  rd_release,
    output wr_ready,
    output rd_data_a, rd_data_b,
    output rd_data_valid, rd_bank_valid,
    output full_count, err_release
  );

  modport master (
    output wr_valid, wr_data,
    output rd_en, rd_addr_a, rd_addr_b,
    output rd_release,
    input  wr_ready,
    input  rd_data_a, rd_data_b,
    input  rd_data_valid, rd_bank_valid,
    input  full_count, err_release
  );

endinterface

// File: rtl/mem_unit_pingpong_mem.sv
// One bank: port A read/write, port B read only.
// Both read ports are registered (one cycle latency).
module true_dual_port_memory #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 96,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             a_en,
  input  logic             a_we,
  input  logic [AW-1:0]    a_addr,
  input  logic [WIDTH-1:0] a_wdata,
  output logic [WIDTH-1:0] a_rdata,
  input  logic             b_en,
  input  logic [AW-1:0]    b_addr,
  output logic [WIDTH-1:0] b_rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Port A: write when a_we, otherwise registered read.
  always_ff @(posedge clk) begin
    if (a_en) begin
      if (a_we) mem[a_addr] <= a_wdata;
      a_rdata <= mem[a_addr];
    end
  end

  // Port B: registered read.
  always_ff @(posedge clk) begin
    if (b_en) b_rdata <= mem[b_addr];
  end

endmodule

// File: rtl/mem_unit_pingpong.sv
// Ping-pong IFM store: producer fills one bank while the
// consumer reads the other, full bank through two ports.
module mem_unit_pingpong
  import mem_unit_pingpong_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int IFM_SIZE         = 16,
  parameter int NUM_CH           = 3,
  parameter int ADDRESS_SIZE_IFM = $clog2(depth_of(IFM_SIZE))
) (
  input logic clk,
  input logic rst_n,
  mem_unit_pingpong_if.slave bus
);

  localparam int DEPTH = depth_of(IFM_SIZE);
  localparam int W     = NUM_CH * DATA_WIDTH;
  localparam int AW    = ADDRESS_SIZE_IFM;

  bank_t                 wr_bank;
  bank_t                 rd_bank;
  bank_t                 rd_sel;
  logic [NUM_BANKS-1:0]  bank_full;
  logic [AW-1:0]         wr_cnt;
  logic                  rd_data_valid;
  logic                  err_release;

  logic wr_fire;
  logic wr_last;
  logic rd_issue;
  logic rel_ok;
  logic rd_bank_valid;

  logic [W-1:0] q_a [NUM_BANKS];
  logic [W-1:0] q_b [NUM_BANKS];

  assign bus.wr_ready  = !bank_full[wr_bank];
  assign rd_bank_valid = bank_full[rd_bank];
  assign wr_fire  = bus.wr_valid & bus.wr_ready;
  assign wr_last  = wr_cnt == AW'(DEPTH - 1);
  assign rd_issue = bus.rd_en & rd_bank_valid;
  assign rel_ok   = bus.rd_release & rd_bank_valid;

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    localparam bank_t ID = bank_t'(i);
    logic we;
    logic re;
    assign we = wr_fire & (wr_bank == ID);
    assign re = rd_issue & (rd_bank == ID);

    true_dual_port_memory #(
      .DEPTH (DEPTH),
      .WIDTH (W),
      .AW    (AW)
    ) u_mem (
      .clk     (clk),
      .a_en    (we | re),
      .a_we    (we),
      .a_addr  (we ? wr_cnt : bus.rd_addr_a),
      .a_wdata (bus.wr_data),
      .a_rdata (q_a[i]),
      .b_en    (re),
      .b_addr  (bus.rd_addr_b),
      .b_rdata (q_b[i])
    );
  end

  // Bank pointers, fill counter, full flags and read tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      rd_sel        <= 1'b0;
      bank_full     <= '0;
      wr_cnt        <= '0;
      rd_data_valid <= 1'b0;
      err_release   <= 1'b0;
    end else begin
      rd_data_valid <= rd_issue;
      if (rd_issue) rd_sel <= rd_bank;
      if (wr_fire) begin
        wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
        if (wr_last) begin
          bank_full[wr_bank] <= 1'b1;
          wr_bank <= ~wr_bank;
        end
      end
      if (rel_ok) begin
        bank_full[rd_bank] <= 1'b0;
        rd_bank <= ~rd_bank;
      end
      if (bus.rd_release && !rd_bank_valid)
        err_release <= 1'b1;
    end
  end

  assign bus.rd_data_valid = rd_data_valid;
  assign bus.rd_data_a = rd_data_valid ? q_a[rd_sel] : '0;
  assign bus.rd_data_b = rd_data_valid ? q_b[rd_sel] : '0;
  assign bus.rd_bank_valid = rd_bank_valid;
  assign bus.err_release   = err_release;
  assign bus.full_count =
    {1'b0, bank_full[0]} + {1'b0, bank_full[1]};

endmodule

// File: tb/tb_mem_unit_pingpong.sv
// Directed bench for the ping-pong IFM store.
// Read data is checked by a queue-driven monitor.
module tb_mem_unit_pingpong;

  localparam int DW  = 32;
  localparam int NCH = 3;
  localparam int AW  = 8;
  localparam int W   = NCH * DW;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t sb [$];

  mem_unit_pingpong_if #(.DW(DW), .NCH(NCH), .AW(AW)) bus ();

  mem_unit_pingpong #(
    .DATA_WIDTH (DW),
    .IFM_SIZE   (16),
    .NUM_CH     (NCH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] pack(input int gen, input int addr);
    logic [W-1:0] r;
    r = '0;
    for (int c = 0; c < NCH; c++)
      r[c*DW +: DW] = {8'(gen), 8'(c), 16'(addr)};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input int gen, input int addr);
    int t;
    t = 0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = pack(gen, addr);
    while (!bus.wr_ready && t < 100) begin
      tick();
      t++;
    end
    if (t == 100) begin
      chk("wr_stall_timeout", 32'(t), 32'd0);
    end else begin
      tick();
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic fill(input int gen, input int start, input int n);
    for (int i = start; i < start + n; i++) push_beat(gen, i);
  endtask

  task automatic rd(input int aa, input int ab, input int gen,
                    input bit expect_data);
    bus.rd_en = 1'b1;
    bus.rd_addr_a = AW'(aa);
    bus.rd_addr_b = AW'(ab);
    if (expect_data)
      sb.push_back('{a: pack(gen, aa), b: pack(gen, ab)});
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic release_pulse();
    bus.rd_release = 1'b1;
    tick();
    bus.rd_release = 1'b0;
  endtask

  task automatic flags(input string tag, input logic rdy,
                       input logic bv, input logic [1:0] fc,
                       input logic err);
    chk({tag, "_wr_ready"}, 32'(bus.wr_ready), 32'(rdy));
    chk({tag, "_bank_valid"}, 32'(bus.rd_bank_valid), 32'(bv));
    chk({tag, "_full_count"}, 32'(bus.full_count), 32'(fc));
    chk({tag, "_err"}, 32'(bus.err_release), 32'(err));
  endtask

  // Pops one expected pair per valid beat; zero data otherwise.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.rd_data_valid) begin
        if (sb.size() == 0) begin
          chk("rd_unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          total++;
          if (bus.rd_data_a !== e.a) begin
            bad++;
            $display("FAIL rd_data_a got=%h want=%h",
                     bus.rd_data_a, e.a);
          end
          total++;
          if (bus.rd_data_b !== e.b) begin
            bad++;
            $display("FAIL rd_data_b got=%h want=%h",
                     bus.rd_data_b, e.b);
          end
        end
      end else if (rst_n) begin
        chk("rd_idle_zero_a", 32'(|bus.rd_data_a), 32'd0);
        chk("rd_idle_zero_b", 32'(|bus.rd_data_b), 32'd0);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bus.wr_valid   = 1'b0;
    bus.wr_data    = '0;
    bus.rd_en      = 1'b0;
    bus.rd_addr_a  = '0;
    bus.rd_addr_b  = '0;
    bus.rd_release = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    flags("reset", 1'b1, 1'b0, 2'd0, 1'b0);
    chk("reset_rd_valid", 32'(bus.rd_data_valid), 32'd0);
    rst_n = 1'b1;
    tick();

    // read request with no full bank is dropped
    rd(1, 2, 0, 1'b0);

    // fill bank0
    fill(1, 0, 256);
    flags("fill0", 1'b1, 1'b1, 2'd1, 1'b0);
    rd(5, 200, 1, 1'b1);
    rd(255, 0, 1, 1'b1);

    // fill bank1, then the next beat stalls
    fill(2, 0, 256);
    flags("both_full", 1'b0, 1'b1, 2'd2, 1'b0);
    bus.wr_valid = 1'b1;
    bus.wr_data  = pack(3, 0);
    repeat (3) begin
      tick();
      chk("stall_wr_ready", 32'(bus.wr_ready), 32'd0);
      chk("stall_full_count", 32'(bus.full_count), 32'd2);
    end

    // release bank0 with a read in the same cycle
    bus.rd_release = 1'b1;
    bus.rd_en = 1'b1;
    bus.rd_addr_a = 8'd7;
    bus.rd_addr_b = 8'd8;
    sb.push_back('{a: pack(1, 7), b: pack(1, 8)});
    tick();
    bus.rd_release = 1'b0;
    bus.rd_en = 1'b0;
    flags("rel0", 1'b1, 1'b1, 2'd1, 1'b0);
    tick();
    bus.wr_valid = 1'b0;
    fill(3, 1, 255);
    chk("refill_full_count", 32'(bus.full_count), 32'd2);
    rd(0, 255, 2, 1'b1);

    // release bank1, bank0 refill readable from address 0
    release_pulse();
    flags("rel1", 1'b1, 1'b1, 2'd1, 1'b0);
    rd(0, 250, 3, 1'b1);

    // final beat of bank1 together with release of bank0
    fill(4, 0, 255);
    bus.rd_release = 1'b1;
    push_beat(4, 255);
    bus.rd_release = 1'b0;
    flags("simul", 1'b1, 1'b1, 2'd1, 1'b0);
    rd(0, 128, 4, 1'b1);

    // empty both banks, then an illegal release
    release_pulse();
    flags("empty", 1'b1, 1'b0, 2'd0, 1'b0);
    rd(3, 4, 0, 1'b0);
    release_pulse();
    flags("err", 1'b1, 1'b0, 2'd0, 1'b1);
    repeat (3) tick();
    chk("err_sticky", 32'(bus.err_release), 32'd1);
    fill(5, 0, 256);
    flags("after_err", 1'b1, 1'b1, 2'd1, 1'b1);
    rd(1, 2, 5, 1'b1);

    // reset in the middle of a fill
    fill(6, 0, 100);
    rst_n = 1'b0;
    #1;
    flags("mid_rst", 1'b1, 1'b0, 2'd0, 1'b0);
    chk("mid_rst_rd_valid", 32'(bus.rd_data_valid), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    fill(7, 0, 256);
    flags("post_rst", 1'b1, 1'b1, 2'd1, 1'b0);
    rd(0, 99, 7, 1'b1);
    rd(100, 255, 7, 1'b1);

    repeat (4) tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
